// File: rtl/circular_buffer_pkg.sv
// Shared types for the circular buffer and its driver: action codes and driver FSM states.
package circular_buffer_pkg;

  localparam int unsigned ActionW = 2;
  localparam int unsigned StateW  = 3;

  typedef enum logic [ActionW-1:0] {
    NOP    = 2'd0,
    CLEAR  = 2'd1,
    ADD    = 2'd2,
    REMOVE = 2'd3
  } action_e;

  typedef enum logic [StateW-1:0] {
    IDLE   = 3'd0,
    PUSH   = 3'd1,
    POP    = 3'd2,
    FLUSH  = 3'd3,
    SETTLE = 3'd4
  } state_e;

endpackage

// File: rtl/circular_buffer_driver.sv
// Sole initiator of the circular buffer's action-code interface. Turns an upstream
// valid/ready push stream, a downstream valid/ready pop stream and a flush request
// into one-cycle action pulses, waiting out the buffer's posedge-sample /
// negedge-update latency in SETTLE before looking at its outputs.
// Optional: define CIRCULAR_BUFFER_DRIVER_STATS_EN to add pushCount, popCount and
// refusedCount saturating counters.
module circular_buffer_driver
  import circular_buffer_pkg::*;
#(
  parameter int unsigned NSize  = 3,
  parameter int unsigned NWidth = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [NWidth:0]    inData,
  input  logic               inValid,
  output logic               inReady,
  output logic [NWidth:0]    outData,
  output logic               outValid,
  input  logic               outReady,
  output logic [ActionW-1:0] bufAction,
  output logic [NWidth:0]    bufIn,
  input  logic [NWidth:0]    bufOut,
  input  logic [NSize:0]     bufInRemainder,
  input  logic [NSize:0]     bufOutRemainder,
  output logic               busy,
  output logic               dropped
`ifdef CIRCULAR_BUFFER_DRIVER_STATS_EN
  ,
  output logic [15:0]        pushCount,
  output logic [15:0]        popCount,
  output logic [15:0]        refusedCount
`endif
);

  state_e          state_q, state_d;
  state_e          prev_q, prev_d;        // operation SETTLE is finishing
  state_e          last_op_q, last_op_d;  // PUSH or POP, for tie-breaking
  logic [NSize:0]  snap_q, snap_d;        // occupancy when the operation was issued
  logic            pend_q, pend_d;        // flush seen while busy
  action_e         act_d;
  logic [NWidth:0] bufin_d, odata_d;
  logic            ovalid_d, dropped_d;

  logic pop_elig, push_elig, grant_push, grant_pop, changed;

  // Eligibility and round-robin arbitration between push and pop
  assign pop_elig   = (bufOutRemainder != '0) && !outValid;
  assign push_elig  = inValid && (bufInRemainder != '0);
  assign grant_push = push_elig && (!pop_elig || (last_op_q == POP));
  assign grant_pop  = pop_elig && (!push_elig || (last_op_q == PUSH));
  assign changed    = (bufOutRemainder != snap_q);
  assign inReady    = (state_q == IDLE) && !flush && !pend_q && grant_push;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    last_op_d = last_op_q;
    snap_d    = snap_q;
    pend_d    = pend_q || (flush && (state_q != IDLE));
    act_d     = NOP;
    bufin_d   = bufIn;
    odata_d   = outData;
    ovalid_d  = outValid && !outReady;
    dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush || pend_q) begin
          state_d  = FLUSH;
          act_d    = CLEAR;
          ovalid_d = 1'b0;
          pend_d   = 1'b0;
        end else if (grant_push) begin
          state_d = PUSH;
          act_d   = ADD;
          bufin_d = inData;
          snap_d  = bufOutRemainder;
        end else if (grant_pop) begin
          state_d = POP;
          act_d   = REMOVE;
          snap_d  = bufOutRemainder;
        end
      end
      PUSH, POP: begin
        state_d   = SETTLE;
        prev_d    = state_q;
        last_op_d = state_q;
      end
      FLUSH: begin
        state_d = SETTLE;
        prev_d  = FLUSH;
      end
      SETTLE: begin
        state_d = IDLE;
        if ((prev_q == POP) && changed) begin
          odata_d  = bufOut;
          ovalid_d = 1'b1;
        end
        if ((prev_q == PUSH) && !changed) dropped_d = 1'b1;
      end
      default: begin
        state_d  = FLUSH;
        act_d    = CLEAR;
        ovalid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset always starts with a buffer clear
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FLUSH;
      prev_q    <= FLUSH;
      last_op_q <= POP;
      snap_q    <= '0;
      pend_q    <= 1'b0;
      bufAction <= ActionW'(CLEAR);
      bufIn     <= '0;
      outData   <= '0;
      outValid  <= 1'b0;
      busy      <= 1'b1;
      dropped   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      last_op_q <= last_op_d;
      snap_q    <= snap_d;
      pend_q    <= pend_d;
      bufAction <= ActionW'(act_d);
      bufIn     <= bufin_d;
      outData   <= odata_d;
      outValid  <= ovalid_d;
      busy      <= (state_d != IDLE);
      dropped   <= dropped_d;
    end
  end

`ifdef CIRCULAR_BUFFER_DRIVER_STATS_EN
  logic in_settle, push_ok, pop_ok, refused, flush_done;

  assign in_settle  = (state_q == SETTLE);
  assign push_ok    = in_settle && (prev_q == PUSH) && changed;
  assign pop_ok     = in_settle && (prev_q == POP) && changed;
  assign refused    = in_settle && ((prev_q == PUSH) || (prev_q == POP)) && !changed;
  assign flush_done = in_settle && (prev_q == FLUSH);

  // Saturating operation counters, cleared by reset and by a completed flush
  always_ff @(posedge clock) begin : g_stats
    if (reset || flush_done) begin
      pushCount    <= '0;
      popCount     <= '0;
      refusedCount <= '0;
    end else begin
      if (push_ok && (pushCount != 16'hFFFF))       pushCount    <= pushCount + 16'd1;
      if (pop_ok && (popCount != 16'hFFFF))         popCount     <= popCount + 16'd1;
      if (refused && (refusedCount != 16'hFFFF))    refusedCount <= refusedCount + 16'd1;
    end
  end
`endif

endmodule
